result_display_driver: RTL and testbench
========================================

Name: result_display_driver

Overview:
Output-side counterpart of the keypad entry path. It accepts the signed 16-bit Booth product on a load strobe and converts it to sign-magnitude BCD using a sequential double-dabble engine. It then drives a 6-position multiplexed common-anode seven-segment display: five decimal digits plus a sign position. It sits between the multiplier result register and the board display pins.

Parameters:
- SCAN_DIV, 50000, clk cycles each display position is held before the scan advances; legal range is 2 or more.
- WIDTH, 16, product width. Fixed at 16 for this revision; the bench checks only 16.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- load  in  1  one-cycle strobe; captures value when the block is idle
- value  in  16  signed two's-complement product
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse when a new result is published
- bcd_out  out  20  published magnitude as 5 BCD nibbles; [3:0] is ones, [19:16] is ten-thousands
- negative  out  1  published sign; 1 means the result is negative
- an  out  6  anode enables, active-low, one-hot; bit0 is ones, bit5 is the sign position
- seg  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}

Behaviour:
- Reset (rst=0 at a clk edge):
  - FSM goes to IDLE; bcd_out=0, negative=0, busy=0, done=0.
  - Scan counter=0, scan index=0, an=6'h3F, seg=7'h7F.
  - Reset has priority over load in the same cycle.
  - Reset during a conversion aborts it; the partial result is discarded.
- FSM states: IDLE, ABS, SHIFT, DONE.
  - IDLE: when load=1, capture value and go to ABS. busy=0.
  - ABS: sign = value[15]; magnitude = sign ? -value : value, taken as 16-bit unsigned. For 0x8000 the magnitude is 32768.
    - Clear the 20-bit BCD scratch and set the bit counter to 0. Go to SHIFT.
  - SHIFT: each cycle, first add 3 to every scratch nibble that is 5 or more. Then shift {scratch, magnitude} left by 1.
    - Run exactly 16 cycles, then go to DONE.
  - DONE: copy scratch to bcd_out and sign to negative. Pulse done=1 for one cycle. Return to IDLE.
- busy=1 in ABS, SHIFT and DONE.
- Latency: load sampled at edge t gives done high in the cycle after edge t+17, i.e. 18 cycles from load acceptance to done.
- load while busy (including the DONE cycle) is ignored. No queueing.
- bcd_out and negative hold the previous result until DONE. The display never shows a partial conversion.
- Scan counter:
  - Free-running from 0 to SCAN_DIV-1. On wrap, the scan index advances 0→1→…→5→0.
  - an and seg are registered and change together at the wrap edge.
  - an = ~(1 << index).
- Index 0..4 shows the corresponding BCD nibble. Segment codes, active-low:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19
  - 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10
  - Any nibble greater than 9 shows blank 0x7F. This is unreachable and is treated as an assertion.
- Index 5: seg=0x3F ('-') when negative=1, otherwise 0x7F.
- Zero result: negative=0, bcd_out=0.

Optional Feature:
- LEADING_ZERO_BLANK_EN
  - Defined: digit positions above the most significant nonzero digit show 0x7F.
    - A zero value still shows '0' at index 0.
    - The sign stays at index 5.
  - Undefined: all five digits are shown, including leading zeros.
- Conversion timing and the bcd_out value are identical in both builds.

Test Plan:
1. Reset, then load with value=16'd1234 → done in the 18th cycle after acceptance; bcd_out=20'h01234, negative=0; busy high for 18 cycles.
2. value=16'hFDC9 (-567) → bcd_out=20'h00567, negative=1; with SCAN_DIV=4 at index 5: an=6'b011111, seg=7'h3F.
3. value=16'h8000 → bcd_out=20'h32768, negative=1. Then value=0 → bcd_out=0, negative=0, index 5 seg=7'h7F.
4. load 1234, then load 999 three cycles later (while busy) → only one done pulse; bcd_out=20'h01234. A following load of 999 after done → 20'h00999.
5. SCAN_DIV=4, result 1234:
   - an steps through 111110, 111101, 111011, 110111, 101111, 011111, holding each for 4 cycles.
   - seg sequence: 0x19, 0x30, 0x24, 0x79, then 0x40 at index 4 (or 0x7F with LEADING_ZERO_BLANK_EN), then 0x7F at index 5.
6. Assert rst=0 for one cycle in the 8th SHIFT cycle of a conversion → next cycle busy=0, bcd_out=0, an=6'h3F, and no done pulse follows.

Source files
------------

// File: rtl/result_display_driver.sv
// Purpose : converts a signed product to sign-magnitude BCD and scans it onto a
//           6-position common-anode seven-segment display (5 digits + sign).
// Latency : 18 cycles from load acceptance to the done pulse.
// Backpressure: none; a load arriving while busy is dropped.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   load/value    : capture strobe and signed product (taken only when idle)
//   busy/done     : conversion in progress / one-cycle publish pulse
//   bcd_out       : published magnitude, 5 BCD nibbles ([3:0] = ones)
//   negative      : published sign
//   an/seg        : active-low anode one-hot (bit5 = sign) and segments {g..a}
//
// Build option: define LEADING_ZERO_BLANK_EN to blank digits above the most
// significant nonzero digit (ones digit always shown).

module result_display_driver #(
    parameter int SCAN_DIV = 50000,
    parameter int WIDTH    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [19:0]      bcd_out,
    output logic             negative,
    output logic [5:0]       an,
    output logic [6:0]       seg
);

    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ABS,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   val_q;
    logic [WIDTH-1:0]   mag;
    logic [19:0]        scratch;
    logic [CNT_W-1:0]   bit_cnt;
    logic               sign_q;

    // Add-3 correction applied to every scratch nibble before each shift.
    logic [19:0]        adj;
    logic [19:0]        scratch_nxt;

    always_comb begin
        adj = scratch;
        for (int i = 0; i < 5; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        scratch_nxt = {adj[18:0], mag[WIDTH-1]};
    end

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            val_q    <= '0;
            mag      <= '0;
            scratch  <= '0;
            bit_cnt  <= '0;
            sign_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            negative <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        val_q <= value;
                        busy  <= 1'b1;
                        state <= ST_ABS;
                    end
                end
                ST_ABS: begin
                    // The most negative input negates to itself, which read as
                    // unsigned is exactly its magnitude.
                    sign_q  <= val_q[WIDTH-1];
                    mag     <= val_q[WIDTH-1] ? -val_q : val_q;
                    scratch <= '0;
                    bit_cnt <= '0;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // A 16-bit magnitude never exceeds 5 digits, so the top
                    // corrected bit must never be shifted out.
                    assert (!adj[19]);
                    scratch <= scratch_nxt;
                    mag     <= {mag[WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                        // Publish together with the done pulse so a consumer
                        // sampling on done sees the new result.
                        bcd_out  <= scratch_nxt;
                        negative <= sign_q;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0]  scan_cnt;
    logic [2:0]         idx;
    logic               wrap;
    logic [3:0]         cur_digit;
    logic [7:0]         blank;
    logic [6:0]         seg_nxt;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'h40;
            4'd1:    dec7 = 7'h79;
            4'd2:    dec7 = 7'h24;
            4'd3:    dec7 = 7'h30;
            4'd4:    dec7 = 7'h19;
            4'd5:    dec7 = 7'h12;
            4'd6:    dec7 = 7'h02;
            4'd7:    dec7 = 7'h78;
            4'd8:    dec7 = 7'h00;
            4'd9:    dec7 = 7'h10;
            default: dec7 = 7'h7F;
        endcase
    endfunction

    assign wrap = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_comb begin
        case (idx)
            3'd0:    cur_digit = bcd_out[3:0];
            3'd1:    cur_digit = bcd_out[7:4];
            3'd2:    cur_digit = bcd_out[11:8];
            3'd3:    cur_digit = bcd_out[15:12];
            3'd4:    cur_digit = bcd_out[19:16];
            default: cur_digit = 4'd0;
        endcase
    end

    // blank[i] marks digit position i as a leading zero; position 0 never blanks.
    always_comb begin
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        blank[4] = (bcd_out[19:16] == 4'd0);
        blank[3] = blank[4] && (bcd_out[15:12] == 4'd0);
        blank[2] = blank[3] && (bcd_out[11:8]  == 4'd0);
        blank[1] = blank[2] && (bcd_out[7:4]   == 4'd0);
`endif
    end

    always_comb begin
        seg_nxt = 7'h7F;
        if (idx < 3'd5) begin
            if (!blank[idx])
                seg_nxt = dec7(cur_digit);
        end else if (idx == 3'd5) begin
            seg_nxt = negative ? 7'h3F : 7'h7F;
        end
    end

    // The position indexed at the wrap edge is what gets latched onto the pins,
    // then the index moves on; so after reset position 0 is shown first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= 6'h3F;
            seg      <= 7'h7F;
        end else begin
            if (wrap) begin
                if (idx < 3'd5)
                    assert (cur_digit <= 4'd9);
                scan_cnt <= '0;
                an       <= ~(6'd1 << idx);
                seg      <= seg_nxt;
                idx      <= (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_display_driver.sv
// Purpose : self-checking bench for result_display_driver (SCAN_DIV = 4).
// Latency : checks the 18-cycle load-to-done timing and scan hold time.
// Backpressure: exercises loads dropped while a conversion is running.

module tb_result_display_driver;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;
    logic        negative;
    logic [5:0]  an;
    logic [6:0]  seg;

    int checks   = 0;
    int failures = 0;

    result_display_driver #(
        .SCAN_DIV (SCAN_DIV),
        .WIDTH    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .negative (negative),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: magnitude and decimal digits by plain integer arithmetic.
    function automatic int model_mag(input logic [15:0] v);
        int m;
        m = $signed(v);
        if (m < 0) m = -m;
        return m;
    endfunction

    function automatic logic [19:0] model_bcd(input logic [15:0] v);
        int m;
        logic [19:0] r;
        m = model_mag(v);
        r = '0;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] model_seg(input int pos, input int mag, input bit neg);
        int p10;
        p10 = 1;
        if (pos == 5) return neg ? 7'h3F : 7'h7F;
        for (int i = 0; i < pos; i++) p10 = p10 * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (pos > 0 && mag < p10) return 7'h7F;
`endif
        return seg_tab[(mag / p10) % 10];
    endfunction

    function automatic int an_pos(input logic [5:0] a);
        for (int i = 0; i < 6; i++)
            if (a === ~(6'd1 << i)) return i;
        return -1;
    endfunction

    // Called at a falling edge; k counts cycles after the accepting edge.
    task automatic run_conv(input logic [15:0] v, output int first_done,
                            output int n_busy, output int n_done);
        load = 1'b1;
        value = v;
        first_done = -1;
        n_busy = 0;
        n_done = 0;
        @(negedge clk);
        load = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            if (busy === 1'b1) n_busy++;
            if (done === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
            @(negedge clk);
        end
    endtask

    task automatic conv_and_check(input logic [15:0] v);
        int fd, nb, nd;
        run_conv(v, fd, nb, nd);
        check("done_latency", fd, 18);
        check("busy_cycles", nb, 18);
        check("done_pulses", nd, 1);
        check("bcd_out", bcd_out, model_bcd(v));
        check("negative", negative, v[15]);
    endtask

    task automatic check_scan(input logic [15:0] v);
        int mag, prev_pos, pos, run, seen;
        bit neg;
        mag = model_mag(v);
        neg = v[15];
        run = 0;
        seen = 0;
        prev_pos = an_pos(an);
        @(negedge clk);
        for (int k = 0; k < 80; k++) begin
            pos = an_pos(an);
            run++;
            if (pos != prev_pos) begin
                if (seen > 0) check("scan_hold", run - 1, SCAN_DIV);
                check("scan_order", pos, (prev_pos + 1) % 6);
                if (pos >= 0) check("scan_seg", seg, model_seg(pos, mag, neg));
                seen++;
                run = 1;
            end
            prev_pos = pos;
            @(negedge clk);
        end
        check("scan_steps", seen >= 15, 1);
    endtask

    initial begin
        int nd;
        logic [15:0] rv;

        rst = 1'b0;
        load = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bcd", bcd_out, 20'h0);
        check("rst_neg", negative, 1'b0);
        check("rst_an", an, 6'h3F);
        check("rst_seg", seg, 7'h7F);

        // Reset wins over a simultaneous load.
        load = 1'b1;
        value = 16'd100;
        @(negedge clk);
        rst = 1'b1;
        load = 1'b0;
        @(negedge clk);
        check("rst_prio_busy", busy, 1'b0);

        conv_and_check(16'd1234);
        check_scan(16'd1234);

        conv_and_check(16'hFDC9);
        check_scan(16'hFDC9);

        conv_and_check(16'h8000);
        check_scan(16'h8000);
        conv_and_check(16'h0000);
        check_scan(16'h0000);

        conv_and_check(16'h7FFF);
        conv_and_check(16'hFFFF);

        // Load while busy is dropped; only one done follows.
        load = 1'b1;
        value = 16'd1234;
        @(negedge clk);
        load = 1'b0;
        nd = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 3) begin
                load = 1'b1;
                value = 16'd999;
            end else begin
                load = 1'b0;
            end
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        load = 1'b0;
        check("busy_load_pulses", nd, 1);
        check("busy_load_bcd", bcd_out, 20'h01234);
        conv_and_check(16'd999);

        // Randomised values against the arithmetic model.
        for (int i = 0; i < 8; i++) begin
            rv = 16'($urandom);
            conv_and_check(rv);
        end
        rv = 16'($urandom);
        conv_and_check(rv);
        check_scan(rv);

        // Reset in the 8th shift cycle aborts the conversion.
        load = 1'b1;
        value = 16'd4321;
        @(negedge clk);
        load = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_bcd", bcd_out, 20'h0);
        check("abort_an", an, 6'h3F);
        check("abort_seg", seg, 7'h7F);
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1) nd++;
            @(negedge clk);
        end
        check("abort_no_done", nd, 0);
        check("abort_bcd_hold", bcd_out, 20'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
